// File: rtl/or18_operand_loader_pkg.sv
// Shared constants and FSM state type for the 18-bit serial operand loader.
package or18_pkg;
   localparam int unsigned WIDTH = 18;
   localparam int unsigned CNT_W = $clog2(WIDTH);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      PARITY,
      HOLD
   } state_t;
endpackage

// File: rtl/or18_operand_loader_if.sv
// Serial input / parallel operand output bus of the operand loader.
// parity_err exists only when OR18_LOADER_PARITY_EN is defined.
interface or18_operand_loader_if;
   import or18_pkg::*;

   logic             start;
   logic             ser_valid;
   logic             ser_in;
   logic [WIDTH-1:0] a_out;
   logic [WIDTH-1:0] b_out;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             frame_err;
   logic             err_clr;
`ifdef OR18_LOADER_PARITY_EN
   logic             parity_err;

   modport master (output start, ser_valid, ser_in, out_ready, err_clr,
                   input  a_out, b_out, out_valid, busy, frame_err, parity_err);
   modport slave  (input  start, ser_valid, ser_in, out_ready, err_clr,
                   output a_out, b_out, out_valid, busy, frame_err, parity_err);
`else
   modport master (output start, ser_valid, ser_in, out_ready, err_clr,
                   input  a_out, b_out, out_valid, busy, frame_err);
   modport slave  (input  start, ser_valid, ser_in, out_ready, err_clr,
                   output a_out, b_out, out_valid, busy, frame_err);
`endif
endinterface

// File: rtl/or18_sipo_reg.sv
// WIDTH-bit serial-in/parallel-out register written one bit at a time by index.
// q_nxt_c is the register contents including this cycle's write or clear.
module or18_sipo_reg
   import or18_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [CNT_W-1:0] idx,
   input  logic             d,
   output logic [WIDTH-1:0] q_nxt_c
);
   logic [WIDTH-1:0] q;

   always_comb begin
      q_nxt_c = q;
      if (clr) begin
         q_nxt_c = '0;
      end else if (en) begin
         q_nxt_c[idx] = d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else begin
         q <= q_nxt_c;
      end
   end
endmodule

// File: rtl/or18_operand_loader.sv
// Bit-serial receiver assembling operand A then B (LSB first) and presenting them
// with a valid/ready handshake. Optional parity bit check: OR18_LOADER_PARITY_EN.
module or18_operand_loader
   import or18_pkg::*;
(
   input logic                  clk,
   input logic                  rst,
   or18_operand_loader_if.slave bus
);
   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             a_en, b_en, sr_clr;
   logic             ferr_set, perr_set, load_out;
   logic [WIDTH-1:0] a_nxt, b_nxt;

   logic [WIDTH-1:0] a_out_q, b_out_q;
   logic             out_valid_q, busy_q, frame_err_q;

   or18_sipo_reg u_sipo_a (
      .clk     (clk),
      .rst     (rst),
      .en      (a_en),
      .clr     (sr_clr),
      .idx     (cnt),
      .d       (bus.ser_in),
      .q_nxt_c (a_nxt)
   );

   or18_sipo_reg u_sipo_b (
      .clk     (clk),
      .rst     (rst),
      .en      (b_en),
      .clr     (sr_clr),
      .idx     (cnt),
      .d       (bus.ser_in),
      .q_nxt_c (b_nxt)
   );

   // State and bit counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state, capture enables and error/load strobes
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      a_en      = 1'b0;
      b_en      = 1'b0;
      sr_clr    = 1'b0;
      ferr_set  = 1'b0;
      perr_set  = 1'b0;
      load_out  = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = LOAD_A;
               cnt_nxt   = '0;
               sr_clr    = 1'b1;
            end
         end
         LOAD_A, LOAD_B: begin
            if (bus.start) begin
               ferr_set  = 1'b1;
               state_nxt = LOAD_A;
               cnt_nxt   = '0;
               sr_clr    = 1'b1;
            end else if (bus.ser_valid) begin
               a_en = (state == LOAD_A);
               b_en = (state == LOAD_B);
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  cnt_nxt = '0;
                  if (state == LOAD_A) begin
                     state_nxt = LOAD_B;
                  end else begin
`ifdef OR18_LOADER_PARITY_EN
                     state_nxt = PARITY;
`else
                     state_nxt = HOLD;
                     load_out  = 1'b1;
`endif
                  end
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
`ifdef OR18_LOADER_PARITY_EN
         PARITY: begin
            if (bus.start) begin
               ferr_set  = 1'b1;
               state_nxt = LOAD_A;
               cnt_nxt   = '0;
               sr_clr    = 1'b1;
            end else if (bus.ser_valid) begin
               // Even parity: all data bits plus the parity bit must XOR to zero
               if (^{a_nxt, b_nxt, bus.ser_in}) begin
                  perr_set  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = HOLD;
                  load_out  = 1'b1;
               end
            end
         end
`endif
         HOLD: begin
            if (out_valid_q && bus.out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Registered outputs; operands copy atomically when the frame completes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_out_q     <= '0;
         b_out_q     <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         out_valid_q <= (state_nxt == HOLD);
         busy_q      <= (state_nxt == LOAD_A) || (state_nxt == LOAD_B);
         if (load_out) begin
            a_out_q <= a_nxt;
            b_out_q <= b_nxt;
         end
         if (ferr_set) begin
            frame_err_q <= 1'b1;
         end else if (bus.err_clr) begin
            frame_err_q <= 1'b0;
         end
      end
   end

`ifdef OR18_LOADER_PARITY_EN
   logic parity_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity_err_q <= 1'b0;
      end else if (perr_set) begin
         parity_err_q <= 1'b1;
      end else if (bus.err_clr) begin
         parity_err_q <= 1'b0;
      end
   end

   assign bus.parity_err = parity_err_q;
`else
   logic unused_perr;
   assign unused_perr = perr_set;
`endif

   assign bus.a_out     = a_out_q;
   assign bus.b_out     = b_out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_or18_operand_loader.sv
// Directed self-checking bench for or18_operand_loader (also covers OR18_LOADER_PARITY_EN builds).
module tb_or18_operand_loader;
   import or18_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   or18_operand_loader_if bus ();

   or18_operand_loader dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      bus.ser_valid = 1'b1;
      bus.ser_in    = b;
      tick();
      bus.ser_valid = 1'b0;
      bus.ser_in    = 1'b0;
   endtask

   task automatic send_word(input logic [WIDTH-1:0] w, input bit stall);
      for (int i = 0; i < int'(WIDTH); i++) begin
         send_bit(w[i]);
         if (stall) tick();
      end
   endtask

   task automatic send_parity(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef OR18_LOADER_PARITY_EN
      send_bit(^{a, b});
`else
      if (^{a, b} === 1'bx) $display("note: unknown operand bits");
`endif
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #3;
      checks++;
      if (bus.a_out !== 18'h0 || bus.b_out !== 18'h0) begin
         errors++;
         $display("FAIL reset_operands: got a=%h b=%h expected a=0 b=0", bus.a_out, bus.b_out);
      end
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.frame_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got ov=%b busy=%b ferr=%b expected 0 0 0",
                  bus.out_valid, bus.busy, bus.frame_err);
      end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic_frame();
      bus.out_ready = 1'b1;
      do_start();
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy_start: got %b expected 1", bus.busy);
      end
      send_word(18'h2AAAA, 1'b0);
      checks++;
      if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_mid: got busy=%b ov=%b expected busy=1 ov=0", bus.busy, bus.out_valid);
      end
      send_word(18'h15555, 1'b0);
      send_parity(18'h2AAAA, 18'h15555);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_ov: got ov=%b busy=%b expected ov=1 busy=0", bus.out_valid, bus.busy);
      end
      checks++;
      if (bus.a_out !== 18'h2AAAA || bus.b_out !== 18'h15555) begin
         errors++;
         $display("FAIL basic_data: got a=%h b=%h expected a=2aaaa b=15555", bus.a_out, bus.b_out);
      end
      checks++;
      if ((bus.a_out | bus.b_out) !== 18'h3FFFF) begin
         errors++;
         $display("FAIL basic_or: got %h expected 3ffff", bus.a_out | bus.b_out);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.a_out !== 18'h2AAAA || bus.b_out !== 18'h15555) begin
         errors++;
         $display("FAIL basic_after_hs: got ov=%b a=%h b=%h expected ov=0 a=2aaaa b=15555",
                  bus.out_valid, bus.a_out, bus.b_out);
      end
   endtask

   task automatic test_stall_backpressure();
      bus.out_ready = 1'b0;
      // Operands differ from the previous frame so a missed update shows up
      do_start();
      send_word(18'h15555, 1'b1);
      send_word(18'h2AAAA, 1'b1);
      send_parity(18'h15555, 18'h2AAAA);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.a_out !== 18'h15555 || bus.b_out !== 18'h2AAAA) begin
            errors++;
            $display("FAIL stall_hold_%0d: got ov=%b a=%h b=%h expected ov=1 a=15555 b=2aaaa",
                     k, bus.out_valid, bus.a_out, bus.b_out);
         end
         if (k < 4) tick();
      end
      bus.out_ready = 1'b1;
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_drop: got ov=%b expected 0", bus.out_valid);
      end
   endtask

   task automatic test_start_in_hold();
      bus.out_ready = 1'b0;
      do_start();
      send_word(18'h3C0F0, 1'b0);
      send_word(18'h0F3C3, 1'b0);
      send_parity(18'h3C0F0, 18'h0F3C3);
      do_start();
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0 || bus.frame_err !== 1'b0) begin
         errors++;
         $display("FAIL hold_start_flags: got ov=%b busy=%b ferr=%b expected 1 0 0",
                  bus.out_valid, bus.busy, bus.frame_err);
      end
      checks++;
      if (bus.a_out !== 18'h3C0F0 || bus.b_out !== 18'h0F3C3) begin
         errors++;
         $display("FAIL hold_start_data: got a=%h b=%h expected a=3c0f0 b=0f3c3", bus.a_out, bus.b_out);
      end
      // Start coincident with the handshake is dropped
      bus.out_ready = 1'b1;
      do_start();
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.frame_err !== 1'b0) begin
         errors++;
         $display("FAIL hold_hs_start: got ov=%b busy=%b ferr=%b expected 0 0 0",
                  bus.out_valid, bus.busy, bus.frame_err);
      end
   endtask

   task automatic test_restart();
      bus.out_ready = 1'b1;
      do_start();
      send_word(18'h3FFFF, 1'b0);
      for (int i = 0; i < 7; i++) send_bit(1'b1);
      // ser_valid high during the restart cycle must not be captured
      bus.ser_valid = 1'b1;
      bus.ser_in    = 1'b1;
      do_start();
      bus.ser_valid = 1'b0;
      bus.ser_in    = 1'b0;
      checks++;
      if (bus.frame_err !== 1'b1 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL restart_err: got ferr=%b busy=%b expected 1 1", bus.frame_err, bus.busy);
      end
      checks++;
      if (bus.a_out !== 18'h3C0F0 || bus.b_out !== 18'h0F3C3) begin
         errors++;
         $display("FAIL restart_keep: got a=%h b=%h expected a=3c0f0 b=0f3c3", bus.a_out, bus.b_out);
      end
      send_word(18'h00001, 1'b0);
      send_word(18'h20000, 1'b0);
      send_parity(18'h00001, 18'h20000);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.a_out !== 18'h00001 || bus.b_out !== 18'h20000) begin
         errors++;
         $display("FAIL restart_data: got ov=%b a=%h b=%h expected ov=1 a=00001 b=20000",
                  bus.out_valid, bus.a_out, bus.b_out);
      end
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
      checks++;
      if (bus.frame_err !== 1'b0) begin
         errors++;
         $display("FAIL restart_clr: got ferr=%b expected 0", bus.frame_err);
      end
      // Set wins over a simultaneous clear
      do_start();
      for (int i = 0; i < 3; i++) send_bit(1'b0);
      bus.err_clr = 1'b1;
      do_start();
      bus.err_clr = 1'b0;
      checks++;
      if (bus.frame_err !== 1'b1) begin
         errors++;
         $display("FAIL restart_set_wins: got ferr=%b expected 1", bus.frame_err);
      end
      send_word(18'h00FF0, 1'b0);
      send_word(18'h3F00F, 1'b0);
      send_parity(18'h00FF0, 18'h3F00F);
      tick();
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
   endtask

   task automatic test_async_reset();
      bus.out_ready = 1'b1;
      do_start();
      send_word(18'h12345, 1'b0);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      rst = 1'b1;
      #2;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.a_out !== 18'h0 || bus.b_out !== 18'h0) begin
         errors++;
         $display("FAIL async_rst: got ov=%b busy=%b a=%h b=%h expected 0 0 0 0",
                  bus.out_valid, bus.busy, bus.a_out, bus.b_out);
      end
      rst = 1'b0;
      tick();
      do_start();
      send_word(18'h12345, 1'b0);
      send_word(18'h0ABCD, 1'b0);
      send_parity(18'h12345, 18'h0ABCD);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.a_out !== 18'h12345 || bus.b_out !== 18'h0ABCD) begin
         errors++;
         $display("FAIL async_next_frame: got ov=%b a=%h b=%h expected ov=1 a=12345 b=0abcd",
                  bus.out_valid, bus.a_out, bus.b_out);
      end
      tick();
   endtask

`ifdef OR18_LOADER_PARITY_EN
   task automatic test_parity();
      bus.out_ready = 1'b1;
      do_start();
      send_word(18'h00003, 1'b0);
      send_word(18'h00000, 1'b0);
      send_bit(1'b1);
      checks++;
      if (bus.parity_err !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL parity_bad: got perr=%b ov=%b busy=%b expected 1 0 0",
                  bus.parity_err, bus.out_valid, bus.busy);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.a_out !== 18'h12345) begin
         errors++;
         $display("FAIL parity_drop: got ov=%b a=%h expected ov=0 a=12345", bus.out_valid, bus.a_out);
      end
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
      do_start();
      send_word(18'h00003, 1'b0);
      send_word(18'h00000, 1'b0);
      send_bit(1'b0);
      checks++;
      if (bus.parity_err !== 1'b0 || bus.out_valid !== 1'b1 || bus.a_out !== 18'h00003 || bus.b_out !== 18'h0) begin
         errors++;
         $display("FAIL parity_good: got perr=%b ov=%b a=%h b=%h expected 0 1 00003 00000",
                  bus.parity_err, bus.out_valid, bus.a_out, bus.b_out);
      end
      tick();
   endtask
`endif

   initial begin
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.ser_valid = 1'b0;
      bus.ser_in    = 1'b0;
      bus.out_ready = 1'b0;
      bus.err_clr   = 1'b0;
      test_reset();
      test_basic_frame();
      test_stall_backpressure();
      test_start_in_hold();
      test_restart();
      test_async_reset();
`ifdef OR18_LOADER_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
